quadrature_decoder: RTL



---
 rtl/quad_pkg.sv | 12 +
 rtl/quadrature_decoder_if.sv | 29 ++
 rtl/quad_input_filter.sv | 44 ++++
 rtl/quadrature_decoder.sv | 72 +++++++
 4 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: shared types and constants for the quadrature decoder slice.
package quad_pkg;
   typedef logic [1:0] ab_t;
   localparam int DEFAULT_FILTER_CYCLES = 4;
   localparam int VEL_WIDTH = 16;
   localparam logic signed [VEL_WIDTH-1:0] VEL_MAX = 16'sd32767;
   // Forward successor of {A,B}, indexed by the current state: 00->10, 01->00, 10->11, 11->01.
   localparam logic [7:0] FWD_TABLE = 8'b01_11_00_10;
   function automatic ab_t fwd_next(ab_t s);
      return FWD_TABLE[{s, 1'b0} +: 2];
   endfunction
endpackage

// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if: register-block side of the decoder.
// Carries velocity only when QUAD_VELOCITY_EN is defined.
interface quadrature_decoder_if import quad_pkg::*; #(parameter int COUNT_WIDTH = 32) ();
   logic clear;
   logic load;
   logic error_clr;
   logic [COUNT_WIDTH-1:0] load_value;
   logic [COUNT_WIDTH-1:0] position;
   logic step;
   logic direction;
   logic error;
`ifdef QUAD_VELOCITY_EN
   logic signed [VEL_WIDTH-1:0] velocity;
`endif
   modport master (
      output clear, load, load_value, error_clr,
      input position, step, direction, error
`ifdef QUAD_VELOCITY_EN
      , input velocity
`endif
   );
   modport slave (
      input clear, load, load_value, error_clr,
      output position, step, direction, error
`ifdef QUAD_VELOCITY_EN
      , output velocity
`endif
   );
endinterface

// File: rtl/quad_input_filter.sv
// quad_input_filter: two-flop synchronizer plus stability filter on the {A,B} pair.
module quad_input_filter import quad_pkg::*; #(
   parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  ab_t  pins,
   output ab_t  accepted,
   output ab_t  previous,
   output logic update
);
   localparam logic [7:0] LIMIT = 8'(FILTER_CYCLES);
   ab_t s1, s2, cand;
   logic [7:0] cnt, cnt_n;
   logic primed, fire;
   // The first settled level after reset fires even if it equals the reset value.
   always_comb begin
      cnt_n = s2 != cand ? 8'd1 : cnt == LIMIT ? cnt : cnt + 8'd1;
      fire = cnt_n == LIMIT && (s2 != accepted || !primed);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         cand <= '0;
         cnt <= '0;
         accepted <= '0;
         previous <= '0;
         update <= 1'b0;
         primed <= 1'b0;
      end else begin
         s1 <= pins;
         s2 <= s1;
         cand <= s2;
         cnt <= cnt_n;
         update <= fire;
         if (fire) begin
            accepted <= s2;
            previous <= accepted;
            primed <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: filtered quadrature pins to signed position, step/direction and sticky error.
// Optional windowed velocity output enabled by QUAD_VELOCITY_EN.
module quadrature_decoder import quad_pkg::*; #(
   parameter int COUNT_WIDTH = 32,
   parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
`ifdef QUAD_VELOCITY_EN
   , parameter int VEL_WINDOW = 65536
`endif
) (
   input logic clk,
   input logic reset,
   input logic quad_a,
   input logic quad_b,
   quadrature_decoder_if.slave bus
);
   ab_t cur, prev;
   logic upd, init, fwd, rev, bad;
   quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
      .clk(clk),
      .reset(reset),
      .pins({quad_a, quad_b}),
      .accepted(cur),
      .previous(prev),
      .update(upd)
   );
   // The first update only adopts the pin state; init gates all decoding.
   always_comb begin
      fwd = upd && init && fwd_next(prev) == cur;
      rev = upd && init && fwd_next(cur) == prev;
      bad = upd && init && (prev ^ cur) == 2'b11;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.position <= '0;
         bus.step <= 1'b0;
         bus.direction <= 1'b0;
         bus.error <= 1'b0;
         init <= 1'b0;
      end else begin
         bus.position <= bus.clear ? '0 :
                         bus.load ? bus.load_value :
                         fwd ? bus.position + COUNT_WIDTH'(1) :
                         rev ? bus.position - COUNT_WIDTH'(1) : bus.position;
         bus.step <= fwd | rev;
         bus.direction <= fwd | rev ? fwd : bus.direction;
         bus.error <= bad | (bus.error & ~bus.error_clr);
         init <= init | upd;
      end
   end
`ifdef QUAD_VELOCITY_EN
   localparam int WW = $clog2(VEL_WINDOW);
   logic [WW-1:0] wcnt;
   logic signed [VEL_WIDTH-1:0] vacc, vacc_n;
   logic wend;
   always_comb begin
      wend = wcnt == WW'(VEL_WINDOW - 1);
      vacc_n = fwd && vacc != VEL_MAX ? vacc + VEL_WIDTH'(1) :
               rev && vacc != -VEL_MAX ? vacc - VEL_WIDTH'(1) : vacc;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt <= '0;
         vacc <= '0;
         bus.velocity <= '0;
      end else begin
         wcnt <= wend ? '0 : wcnt + WW'(1);
         vacc <= wend ? '0 : vacc_n;
         bus.velocity <= wend ? vacc_n : bus.velocity;
      end
   end
`endif
endmodule
